// File: rtl/spmi_tx.sv
// spmi_tx: single-master SPMI-style serial frame transmitter.
//
// Sends a Sequence Start Condition (data high then low with spmiclk parked
// low, each half 2*CLK_DIV cycles long), followed by a FRAME_BITS-bit packet
// sent MSB first. Each bit is a low half period, in which the data changes,
// and a high half period, in which the data is held. A PARK half period
// follows, then a one-cycle done pulse.
//
// Optional feature macro: SPMI_TX_PARITY_EN. When defined, the last bit
// transmitted is odd parity over packet[12:1] instead of packet[0].
//
// Ports:
//   sysclk    in   single clock, every register on its rising edge
//   reset     in   synchronous, active-high
//   packet    in   frame payload, bit 12 first, sampled only on accept
//   send      in   transmit request
//   busy      out  frame in progress
//   done      out  one-cycle pulse when a frame completes
//   spmiclk   out  registered serial clock
//   spmidat   out  registered serial data
//   fsm_state out  current FSM state (debug visibility)
//
// Handshake: a request is accepted on any rising edge where send=1 and
// busy=0; the packet is latched on that edge. send while busy is dropped,
// never queued. A send held in the done cycle starts the next frame at once.

module spmi_tx #(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = 13
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] packet,
  input  logic                  send,
  output logic                  busy,
  output logic                  done,
  output logic                  spmiclk,
  output logic                  spmidat,
  output logic [2:0]            fsm_state
);

  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [7:0]    HC_LOAD   = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BCNT_LOAD = BW'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SSC_HI = 3'd1,
    SSC_LO = 3'd2,
    BIT_LO = 3'd3,
    BIT_HI = 3'd4,
    PARK   = 3'd5
  } state_t;

  state_t                state, state_n;
  logic [7:0]            hc, hc_n;
  logic                  half, half_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic [BW-1:0]         bcnt, bcnt_n;
  logic                  done_n, clk_n, dat_n;
  logic [FRAME_BITS-1:0] load_word;

`ifdef SPMI_TX_PARITY_EN
  // ^packet ^ packet[0] equals ^packet[FRAME_BITS-1:1]; written this way so
  // every packet bit has a reader. The inversion makes the total odd.
  assign load_word = {packet[FRAME_BITS-1:1], ~((^packet) ^ packet[0])};
`else
  assign load_word = packet;
`endif

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state   <= IDLE;
      hc      <= 8'd0;
      half    <= 1'b0;
      shreg   <= '0;
      bcnt    <= '0;
      done    <= 1'b0;
      spmiclk <= 1'b0;
      spmidat <= 1'b0;
    end else begin
      state   <= state_n;
      hc      <= hc_n;
      half    <= half_n;
      shreg   <= shreg_n;
      bcnt    <= bcnt_n;
      done    <= done_n;
      spmiclk <= clk_n;
      spmidat <= dat_n;
    end
  end

  always_comb begin
    state_n = state;
    hc_n    = hc;
    half_n  = half;
    shreg_n = shreg;
    bcnt_n  = bcnt;
    done_n  = 1'b0;
    if (hc != 8'd0) hc_n = hc - 8'd1;

    case (state)
      IDLE: begin
        if (send) begin
          shreg_n = load_word;
          bcnt_n  = BCNT_LOAD;
          hc_n    = HC_LOAD;
          half_n  = 1'b0;
          state_n = SSC_HI;
        end
      end
      // SSC halves last 2*CLK_DIV cycles; the 8-bit counter only covers
      // CLK_DIV, so each SSC state runs two counter passes tracked by half.
      SSC_HI: begin
        if (hc == 8'd0) begin
          hc_n   = HC_LOAD;
          half_n = ~half;
          if (half) state_n = SSC_LO;
        end
      end
      SSC_LO: begin
        if (hc == 8'd0) begin
          hc_n   = HC_LOAD;
          half_n = ~half;
          if (half) state_n = BIT_LO;
        end
      end
      BIT_LO: begin
        if (hc == 8'd0) begin
          hc_n    = HC_LOAD;
          state_n = BIT_HI;
        end
      end
      BIT_HI: begin
        if (hc == 8'd0) begin
          hc_n    = HC_LOAD;
          shreg_n = {shreg[FRAME_BITS-2:0], 1'b0};
          if (bcnt != '0) begin
            bcnt_n  = bcnt - 1'b1;
            state_n = BIT_LO;
          end else begin
            state_n = PARK;
          end
        end
      end
      PARK: begin
        if (hc == 8'd0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    // The shift only happens when leaving BIT_HI, so data changes only on
    // entry to BIT_LO and stays put through the high half.
    clk_n = (state_n == BIT_HI);
    dat_n = (state_n == SSC_HI) ||
            (((state_n == BIT_LO) || (state_n == BIT_HI)) && shreg_n[FRAME_BITS-1]);
  end

endmodule

// File: tb/tb_spmi_tx.sv
module tb_spmi_tx;

  localparam int D = 2;
  localparam int L = 31 * D;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic [12:0] packet = '0;
  logic        send   = 1'b0;
  logic        busy, done, spmiclk, spmidat;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  spmi_tx #(.CLK_DIV(D), .FRAME_BITS(13)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .packet    (packet),
    .send      (send),
    .busy      (busy),
    .done      (done),
    .spmiclk   (spmiclk),
    .spmidat   (spmidat),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 sysclk = ~sysclk;

  // trace of one frame, index = cycle number after the accept edge
  logic tr_clk [0:255];
  logic tr_dat [0:255];
  logic tr_busy[0:255];
  logic tr_done[0:255];

  logic [12:0] a_bits;
  int a_nbits, a_first, a_last, a_busy, a_done, a_done_at;
  int a_clk_hi, a_unstable, a_ssc_hi, a_ssc_lo;

  // expected transmitted word for a latched packet
  function automatic logic [12:0] exp_word(input logic [12:0] p);
`ifdef SPMI_TX_PARITY_EN
    return {p[12:1], ~(^p[12:1])};
`else
    return p;
`endif
  endfunction

  // driver / monitor: records limit cycles, sampled on the falling edge
  task automatic capture(input int limit, input int drop_k, input int resend_k,
                         input logic [12:0] resend_pkt);
    tr_clk[0] = 1'b0;
    tr_dat[0] = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge sysclk);
      tr_clk[k]  = spmiclk;
      tr_dat[k]  = spmidat;
      tr_busy[k] = busy;
      tr_done[k] = done;
      if (k == drop_k) send = 1'b0;
      if (k == resend_k) begin
        send   = 1'b1;
        packet = resend_pkt;
      end
    end
  endtask

  task automatic analyze(input int limit);
    a_bits = '0; a_nbits = 0; a_first = -1; a_last = -1;
    a_busy = 0; a_done = 0; a_done_at = -1;
    a_clk_hi = 0; a_unstable = 0; a_ssc_hi = 0; a_ssc_lo = 0;
    for (int k = 1; k <= limit; k++) begin
      if (tr_busy[k]) a_busy++;
      if (tr_done[k]) begin
        a_done++;
        if (a_done_at < 0) a_done_at = k;
      end
      if (tr_clk[k]) begin
        a_clk_hi++;
        if (tr_dat[k] !== tr_dat[k-1]) a_unstable++;
        if (!tr_clk[k-1]) begin
          a_bits = {a_bits[11:0], tr_dat[k]};
          a_nbits++;
          if (a_first < 0) a_first = k;
          a_last = k;
        end
      end
      if (k <= 2*D && tr_busy[k] && tr_dat[k] && !tr_clk[k]) a_ssc_hi++;
      if (k > 2*D && k <= 4*D && tr_busy[k] && !tr_dat[k] && !tr_clk[k]) a_ssc_lo++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    send  = 1'b0;
    repeat (10) @(negedge sysclk);
    reset = 1'b0;
    repeat (2) @(negedge sysclk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
    n_checks++; if (spmiclk !== 1'b0) begin n_fail++; $display("FAIL reset spmiclk: got %b expected 0", spmiclk); end
    n_checks++; if (spmidat !== 1'b0) begin n_fail++; $display("FAIL reset spmidat: got %b expected 0", spmidat); end
    n_checks++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL reset state: got %0d expected 0", fsm_state); end
  endtask

  task automatic test_frame(input logic [12:0] pkt, input string tag);
    packet = pkt;
    send   = 1'b1;
    capture(L + 8, 1, 0, 13'h0);
    analyze(L + 8);
    n_checks++; if (a_ssc_hi != 2*D) begin n_fail++; $display("FAIL %s ssc_hi: got %0d expected %0d", tag, a_ssc_hi, 2*D); end
    n_checks++; if (a_ssc_lo != 2*D) begin n_fail++; $display("FAIL %s ssc_lo: got %0d expected %0d", tag, a_ssc_lo, 2*D); end
    n_checks++; if (a_nbits != 13) begin n_fail++; $display("FAIL %s nbits: got %0d expected 13", tag, a_nbits); end
    n_checks++; if (a_bits !== exp_word(pkt)) begin n_fail++; $display("FAIL %s bits: got %h expected %h", tag, a_bits, exp_word(pkt)); end
    n_checks++; if (a_first != 5*D + 1) begin n_fail++; $display("FAIL %s first_rise: got %0d expected %0d", tag, a_first, 5*D + 1); end
    n_checks++; if (a_last != 29*D + 1) begin n_fail++; $display("FAIL %s last_rise: got %0d expected %0d", tag, a_last, 29*D + 1); end
    n_checks++; if (a_clk_hi != 13*D) begin n_fail++; $display("FAIL %s clk_high: got %0d expected %0d", tag, a_clk_hi, 13*D); end
    n_checks++; if (a_unstable != 0) begin n_fail++; $display("FAIL %s dat_stable: got %0d changes expected 0", tag, a_unstable); end
    n_checks++; if (a_busy != L) begin n_fail++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, a_busy, L); end
    n_checks++; if (a_done != 1) begin n_fail++; $display("FAIL %s done_count: got %0d expected 1", tag, a_done); end
    n_checks++; if (a_done_at != L + 1) begin n_fail++; $display("FAIL %s done_at: got %0d expected %0d", tag, a_done_at, L + 1); end
  endtask

  task automatic test_back_to_back();
    packet = 13'h2F5;
    send   = 1'b1;
    capture(L + 1, 1, L + 1, 13'h1A05);
    analyze(L + 1);
    n_checks++; if (a_bits !== exp_word(13'h2F5)) begin n_fail++; $display("FAIL b2b first bits: got %h expected %h", a_bits, exp_word(13'h2F5)); end
    n_checks++; if (a_done_at != L + 1) begin n_fail++; $display("FAIL b2b first done_at: got %0d expected %0d", a_done_at, L + 1); end
    capture(L + 8, 1, 0, 13'h0);
    analyze(L + 8);
    n_checks++; if (tr_busy[1] !== 1'b1) begin n_fail++; $display("FAIL b2b no_gap busy: got %b expected 1", tr_busy[1]); end
    n_checks++; if (tr_dat[1] !== 1'b1) begin n_fail++; $display("FAIL b2b no_gap ssc: got %b expected 1", tr_dat[1]); end
    n_checks++; if (a_bits !== exp_word(13'h1A05)) begin n_fail++; $display("FAIL b2b second bits: got %h expected %h", a_bits, exp_word(13'h1A05)); end
    n_checks++; if (a_busy != L) begin n_fail++; $display("FAIL b2b second busy_cycles: got %0d expected %0d", a_busy, L); end
    n_checks++; if (a_done_at != L + 1) begin n_fail++; $display("FAIL b2b second done_at: got %0d expected %0d", a_done_at, L + 1); end
  endtask

  task automatic test_send_held();
    packet = 13'h0F1;
    send   = 1'b1;
    // send stays high; packet changes mid-frame at cycle 20
    capture(L + 1, 0, 20, 13'h155);
    analyze(L + 1);
    n_checks++; if (a_bits !== exp_word(13'h0F1)) begin n_fail++; $display("FAIL held first bits: got %h expected %h", a_bits, exp_word(13'h0F1)); end
    n_checks++; if (a_busy != L) begin n_fail++; $display("FAIL held first busy_cycles: got %0d expected %0d", a_busy, L); end
    n_checks++; if (a_done != 1) begin n_fail++; $display("FAIL held first done_count: got %0d expected 1", a_done); end
    capture(L + 8, 1, 0, 13'h0);
    analyze(L + 8);
    n_checks++; if (a_bits !== exp_word(13'h155)) begin n_fail++; $display("FAIL held second bits: got %h expected %h", a_bits, exp_word(13'h155)); end
    n_checks++; if (a_busy != L) begin n_fail++; $display("FAIL held second busy_cycles: got %0d expected %0d", a_busy, L); end
    n_checks++; if (a_done != 1) begin n_fail++; $display("FAIL held second done_count: got %0d expected 1", a_done); end
  endtask

  task automatic test_reset_mid_frame();
    int dones;
    int busies;
    packet = 13'h2F5;
    send   = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge sysclk);
      if (k == 1) send = 1'b0;
    end
    // cycle 30 sits in the low half of bit index 5, which is a 1
    n_checks++; if (busy !== 1'b1 || spmidat !== 1'b1) begin n_fail++; $display("FAIL midreset pre busy/dat: got %b/%b expected 1/1", busy, spmidat); end
    reset = 1'b1;
    @(negedge sysclk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b expected 0", busy); end
    n_checks++; if (spmiclk !== 1'b0 || spmidat !== 1'b0) begin n_fail++; $display("FAIL midreset clk/dat: got %b/%b expected 0/0", spmiclk, spmidat); end
    n_checks++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL midreset state: got %0d expected 0", fsm_state); end
    reset  = 1'b0;
    dones  = 0;
    busies = 0;
    for (int k = 0; k < L + 8; k++) begin
      @(negedge sysclk);
      if (done) dones++;
      if (busy) busies++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midreset done_count: got %0d expected 0", dones); end
    n_checks++; if (busies != 0) begin n_fail++; $display("FAIL midreset busy_after: got %0d expected 0", busies); end
    test_frame(13'h2F5, "after_reset");
  endtask

  task automatic test_last_bit();
    test_frame(13'h1A04, "last_bit");
`ifdef SPMI_TX_PARITY_EN
    n_checks++; if (a_bits[0] !== 1'b1) begin n_fail++; $display("FAIL last_bit parity: got %b expected 1", a_bits[0]); end
`else
    n_checks++; if (a_bits[0] !== 1'b0) begin n_fail++; $display("FAIL last_bit verbatim: got %b expected 0", a_bits[0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_frame(13'h2F5, "frame_2f5");
    test_back_to_back();
    test_send_held();
    test_reset_mid_frame();
    test_last_bit();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spmi_tx.md
# spmi_tx

Single-master SPMI-style serial frame transmitter, the companion of the `spmi` receiver. It takes a 13-bit packet on the system clock domain and emits a Sequence Start Condition (SSC) followed by the packet MSB-first on `spmiclk`/`spmidat`. It is used as a loopback and stimulus source for receiver bring-up on the FPGA, and as the transmit side of the bus interface.

## Interface
- `CLK_DIV`, 2: sysclk cycles per half SPMI bit period; legal range 1..255.
- `FRAME_BITS`, 13: bits per frame after SSC; fixed at 13 in this revision.
- `sysclk` in 1: single clock; every register is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `packet` in 13: frame payload, bit 12 sent first; sampled only on accept.
- `send` in 1: request; accepted when `send & ~busy`.
- `busy` out 1: frame in progress; reset 0.
- `done` out 1: one-cycle pulse at frame completion; reset 0.
- `spmiclk` out 1: registered serial clock; reset 0.
- `spmidat` out 1: registered serial data; reset 0.

## Operation
- States: IDLE, SSC_HI, SSC_LO, BIT_LO, BIT_HI, PARK.
- Half-period counter `hc`, 8 bits: loads `CLK_DIV-1` on every state entry and counts down. The state advances when `hc==0`.
- IDLE: `spmiclk=0`, `spmidat=0`. On accept, latch `packet` into the shift register and load bit counter = 12. Next state is SSC_HI.
- SSC_HI: `spmidat=1`, `spmiclk=0` for 2·CLK_DIV cycles.
- SSC_LO: `spmidat=0`, `spmiclk=0` for 2·CLK_DIV cycles.
- BIT_LO: `spmiclk=0` and `spmidat=` shift-register MSB for CLK_DIV cycles. Data changes only on entry to BIT_LO.
- BIT_HI: `spmiclk=1` for CLK_DIV cycles; `spmidat` is held stable across the rising edge. On exit, shift left by 1.
  - Bit counter ≠ 0: decrement and go to BIT_LO.
  - Bit counter = 0: go to PARK.
- PARK: `spmiclk=0`, `spmidat=0` for CLK_DIV cycles, then go to IDLE.
- `send` while `busy` is ignored and not queued. `packet` changes during a frame have no effect.
- Reset in any state: the next edge forces IDLE and all outputs to 0. The frame is abandoned and no `done` pulse is produced.

## Timing
- Accept at edge N: `busy=1` and `spmidat=1` (SSC_HI) are visible from cycle N+1.
- Frame length L = 4·CLK_DIV (SSC) + 26·CLK_DIV (bits) + CLK_DIV (park) = 31·CLK_DIV cycles. This is 62 for CLK_DIV=2.
- `busy` is high for cycles N+1 .. N+L.
- In cycle N+L+1, `busy=0` and `done=1` for exactly one cycle.
- A `send` asserted in the `done` cycle is accepted, giving back-to-back frames with zero idle gap beyond PARK.
- `spmiclk` duty cycle is exactly 50% during the bit phase.
- Rising edges of `spmiclk` fall CLK_DIV cycles after each data change.

## Configuration
- `SPMI_TX_PARITY_EN` defined: the transmitted bit 0 is replaced with odd parity over `packet[12:1]`, so `^{packet[12:1], p} == 1`. Latched `packet[0]` is ignored. Frame length and timing are unchanged.
- `SPMI_TX_PARITY_EN` undefined: `packet[0]` is transmitted verbatim and no parity logic is instantiated.

## Test plan
- Reset held 10 cycles, then released -> all outputs 0 and state IDLE.
- CLK_DIV=2, `packet=13'h2F5`, pulse `send` -> `spmidat` high for 4 cycles, then low for 4. Bits sampled on the 13 `spmiclk` rises are 0,0,0,1,0,1,1,1,1,0,1,0,1. `busy` is high for 62 cycles and `done` pulses once at N+63.
- `packet=13'h1A05` sent in the `done` cycle of the previous frame -> accepted with no gap. Rises sample 1,1,0,1,0,0,0,0,0,0,1,0,1.
- `send` held high throughout a frame, with `packet` changed mid-frame -> exactly one frame per accept, carrying the packet latched at accept.
- `reset` asserted at cycle 30 of a frame -> `spmiclk`/`spmidat`/`busy` are 0 on the next cycle and there is no `done`. The next `send` produces a clean full frame.
- With `SPMI_TX_PARITY_EN`, `packet=13'h1A04` -> the last bit transmitted is 1. Without the macro, the last bit is 0.
